bcd_display_scan: RTL and testbench

- Sits directly downstream of the binary-to-BCD converter.
- Takes its 12-bit, 3-digit BCD word and drives a multiplexed 4-digit common-anode 7-segment display.
- Output stage for the spectrum readout: latches the value, scans digits, decodes segments and blanks leading zeros.
- New values are committed only at frame boundaries, so the display never tears.

---
 rtl/bcd_display_scan.sv | 187 ++++++++++++++++++
 tb/tb_bcd_display_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// bcd_display_scan
// Drives a multiplexed 4-digit common-anode 7-segment display from a 3-digit
// BCD word.
// - A new word is captured into a pending register.
// - It is committed to the display register only when the scan wraps from
//   slot 3 back to slot 0, so a frame is never drawn from two values.
// - Leading zeros are blanked, and slot 3 is an unused position that stays dark.
module bcd_display_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  // Inactive output levels depend on the display polarity.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic       DP_OFF  = ACTIVE_LOW ? 1'b1  : 1'b0;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a minus.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  // Converts an active-high segment vector to the physical pin level.
  function automatic logic [6:0] seg_pol(input logic [6:0] pat);
    return ACTIVE_LOW ? ~pat : pat;
  endfunction

  // Converts an active-high anode vector to the physical pin level.
  function automatic logic [3:0] an_pol(input logic [3:0] onehot);
    return ACTIVE_LOW ? ~onehot : onehot;
  endfunction

  // Selects the nibble shown in a slot. Slot 3 has no digit behind it.
  function automatic logic [3:0] slot_digit(input logic [1:0] slot, input logic [11:0] word);
    logic [3:0] nib;
    case (slot)
      2'd0:    nib = word[3:0];
      2'd1:    nib = word[7:4];
      2'd2:    nib = word[11:8];
      default: nib = 4'd0;
    endcase
    return nib;
  endfunction

  // True when the slot must stay dark.
  // - Slot 3 is always dark.
  // - Hundreds are dark when zero.
  // - Tens are dark when both hundreds and tens are zero.
  // Minus nibbles count as nonzero, so they hold the digits to their right lit.
  function automatic logic slot_dark(input logic [1:0] slot, input logic [11:0] word);
    logic hz;
    logic tz;
    logic dark;
    hz = (word[11:8] == 4'd0);
    tz = (word[7:4] == 4'd0);
    case (slot)
      2'd0:    dark = 1'b0;
      2'd1:    dark = LZ_BLANK && hz && tz;
      2'd2:    dark = LZ_BLANK && hz;
      default: dark = 1'b1;
    endcase
    return dark;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    slot_q, slot_d;
  logic [11:0]   disp_q, disp_d;
  logic [11:0]   pend_q, pend_d;
  logic          pending_q, pending_d;
  logic          frame_start_q, frame_start_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic tick;
  logic wrap_tick;

  assign tick      = (presc_q == PRESC_MAX);
  assign wrap_tick = tick && (slot_q == 2'd3);

  // Scan timing, value capture and frame-boundary commit.
  // The commit reads the old pending value before the capture overwrites it.
  // A strobe on the commit tick therefore queues for the following frame.
  always_comb begin
    presc_d       = presc_q + PW'(1);
    slot_d        = slot_q;
    disp_d        = disp_q;
    pend_d        = pend_q;
    pending_d     = pending_q;
    frame_start_d = wrap_tick;

    if (tick) begin
      presc_d = '0;
      slot_d  = slot_q + 2'd1;
    end

    if (wrap_tick && pending_q) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end

    if (bcd_valid) begin
      pend_d    = bcd_in;
      pending_d = 1'b1;
    end
  end

  // Output stage: decodes the current slot of the committed value.
  // The blank input overrides all digits.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    dp_d  = DP_OFF;
    if (!blank && !slot_dark(slot_q, disp_q)) begin
      seg_d = seg_pol(seg_decode(slot_digit(slot_q, disp_q)));
      an_d  = an_pol(4'b0001 << slot_q);
    end
  end

  // Control and data state.
  // Reset discards any pending value and restarts the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      slot_q        <= 2'd0;
      disp_q        <= 12'h000;
      pend_q        <= 12'h000;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      slot_q        <= slot_d;
      disp_q        <= disp_d;
      pend_q        <= pend_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Registered pin drivers.
  // Reset forces them to the inactive level at once, so the display goes dark immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      dp_q  <= DP_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan.
// - Uses SCAN_DIV=4, active-low pins and leading-zero blanking.
// - The reference tracks time as a plain cycle count since reset release.
// - The scan position and frame boundary are derived from that count arithmetically.
module tb_bcd_display_scan;

  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd_in = 12'h000;
  logic        bcd_valid = 1'b0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  bcd_display_scan #(
    .SCAN_DIV  (SD),
    .ACTIVE_LOW(1'b1),
    .LZ_BLANK  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .blank      (blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int          m_cnt;
  logic [11:0] m_disp;
  logic [11:0] m_pend;
  bit          m_pending;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  bit          e_fs;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, obs, exp_v);
    end
  endtask

  // What the pins should show for a given scan position and displayed word.
  function automatic void model_out(input int s, input logic [11:0] w, input bit blk,
                                    output logic [6:0] sg, output logic [3:0] a);
    int h, t, o, d;
    bit off;
    logic [3:0] one;
    logic [6:0] pat;
    h = int'(w[11:8]);
    t = int'(w[7:4]);
    o = int'(w[3:0]);
    d = (s == 0) ? o : (s == 1) ? t : h;
    off = blk || (s == 3) || (s == 2 && h == 0) || (s == 1 && h == 0 && t == 0);
    pat = (d > 9) ? 7'h40 : seg_tab[d];
    one = 4'b0001;
    if (off) begin
      sg = 7'h7F;
      a  = 4'hF;
    end else begin
      sg = ~pat;
      a  = ~(one << s);
    end
  endfunction

  task automatic model_reset();
    m_cnt     = 0;
    m_disp    = 12'h000;
    m_pend    = 12'h000;
    m_pending = 0;
  endtask

  // One clock cycle:
  // 1. Drive inputs and predict the registered outputs.
  // 2. Advance the reference state.
  // 3. Compare at the following falling edge.
  task automatic cycle(input bit v, input logic [11:0] d, input bit b);
    int s;
    bit wrap;
    bcd_valid = v;
    bcd_in    = d;
    blank     = b;
    s = (m_cnt / SD) % 4;
    model_out(s, m_disp, b, e_seg, e_an);
    wrap = ((m_cnt % FRAME) == FRAME - 1);
    if (wrap && m_pending) begin
      m_disp    = m_pend;
      m_pending = 0;
    end
    if (v) begin
      m_pend    = d;
      m_pending = 1;
    end
    e_fs = wrap;
    m_cnt++;
    @(posedge clk);
    @(negedge clk);
    chk("seg", 32'(seg), 32'(e_seg));
    chk("an", 32'(an), 32'(e_an));
    chk("dp", 32'(dp), 32'd1);
    chk("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 12'h000, 1'b0);
  endtask

  // Idles until the next cycle will sit at frame phase p (bounded to one frame).
  task automatic run_to(input int p);
    for (int i = 0; i < FRAME && (m_cnt % FRAME) != p; i++) cycle(1'b0, 12'h000, 1'b0);
  endtask

  task automatic chk_inactive(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_dp"}, 32'(dp), 32'd1);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    logic [3:0] h, t, o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_inactive("reset");
    rst = 1'b0;
    model_reset();

    // Zero display after reset
    idle(20);

    // Mid-frame load shown only after the frame boundary
    run_to(5);
    cycle(1'b1, 12'h255, 1'b0);
    idle(40);

    // Leading-zero blanking and minus digits
    run_to(3);
    cycle(1'b1, 12'h007, 1'b0);
    idle(20);
    cycle(1'b1, 12'h105, 1'b0);
    idle(20);
    cycle(1'b1, 12'h0A3, 1'b0);
    idle(20);

    // Two strobes in one frame: the last one wins
    run_to(2);
    cycle(1'b1, 12'h111, 1'b0);
    idle(3);
    cycle(1'b1, 12'h222, 1'b0);
    idle(40);

    // Strobe on the commit tick waits a frame
    run_to(4);
    cycle(1'b1, 12'h555, 1'b0);
    run_to(FRAME - 1);
    cycle(1'b1, 12'h333, 1'b0);
    idle(36);

    // Reset during slot 2 with a value pending
    run_to(8);
    cycle(1'b1, 12'h444, 1'b0);
    run_to(9);
    rst = 1'b1;
    #1;
    chk_inactive("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(40);

    // Blank in mid-frame leaves scan timing alone
    cycle(1'b1, 12'h987, 1'b0);
    idle(18);
    run_to(6);
    for (int i = 0; i < 5; i++) cycle(1'b0, 12'h000, 1'b1);
    idle(20);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      h = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 10));
      t = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 10));
      o = 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 5) == 0), {h, t, o}, ($urandom_range(0, 11) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
